// File: rtl/float_to_fixed.sv
// float_to_fixed: float {sign,exp,mantissa} -> saturated signed fixed point; 4-cycle latency, 1/cycle, no backpressure.
// Build option FLOAT2FIX_ROUND_EN: round-to-nearest-even; undefined: truncate toward zero.
module float_to_fixed #(
  parameter int ExpWidth      = 8,
  parameter int MantissaWidth = 23,
  parameter int Float_L       = 1 + ExpWidth + MantissaWidth,
  parameter int IntWidth      = 32,
  parameter int FracBits      = 0
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                en,
  input  logic [Float_L-1:0]  Float_A,
  output logic [IntWidth-1:0] Int_C,
  output logic                ovf,
  output logic                inexact,
  output logic                rdy
);

  localparam int Bias = 2**(ExpWidth-1) - 1;
  localparam int SW   = ExpWidth + 2;
  localparam int SigW = MantissaWidth + 1;
  localparam int MagW = IntWidth + 1;
  localparam int RW   = 2*MantissaWidth + 3;

  localparam logic [MagW-1:0]     PosMax = {2'b00, {(IntWidth-1){1'b1}}};
  localparam logic [MagW-1:0]     NegMax = {2'b01, {(IntWidth-1){1'b0}}};
  localparam logic [IntWidth-1:0] SatPos = {1'b0, {(IntWidth-1){1'b1}}};
  localparam logic [IntWidth-1:0] SatNeg = {1'b1, {(IntWidth-1){1'b0}}};

  typedef struct packed {
    logic            sign;
    logic            nan;
    logic            inf;
    logic            flush;
    logic            pre_ovf;
    logic [SW-1:0]   shift;
    logic [SigW-1:0] sig;
  } cls_t;

  typedef struct packed {
    logic            sign;
    logic            nan;
    logic            inf;
    logic            flush;
    logic            pre_ovf;
    logic [MagW-1:0] mag;
    logic            g;
    logic            s;
  } aln_t;

  typedef struct packed {
    logic                sign;
    logic                nan;
    logic                inf;
    logic                ovf;
    logic                inexact;
    logic [IntWidth-1:0] mag;
  } rnd_t;

  logic                s1_vld, s2_vld, s3_vld, s4_vld;
  logic [Float_L-1:0]  a_dat;
  cls_t                cls_dat, cls_d;
  aln_t                aln_dat, aln_d;
  rnd_t                rnd_dat, rnd_d;

  logic                     a_sign;
  logic [ExpWidth-1:0]      a_exp;
  logic [MantissaWidth-1:0] a_man;
  int                       e_unb;

  assign {a_sign, a_exp, a_man} = a_dat;

  // Stage 1: classify. Zero, denormal and NaN/Inf leave sig/shift at 0 so later stages yield mag=0.
  always_comb begin
    cls_d      = '0;
    e_unb      = int'(a_exp) - Bias;
    cls_d.sign = a_sign;
    if (a_exp == '1) begin
      cls_d.nan = (a_man != '0);
      cls_d.inf = (a_man == '0);
    end else if (a_exp == '0) begin
      cls_d.flush = (a_man != '0);
    end else begin
      cls_d.sig     = {1'b1, a_man};
      cls_d.shift   = SW'(e_unb - MantissaWidth + FracBits);
      cls_d.pre_ovf = (e_unb + FracBits >= IntWidth);
    end
  end

  logic [SW-1:0] rsh;
  logic [RW-1:0] rwide;

  // Stage 2: align. Right shifts keep the integer part, guard bit and sticky OR.
  always_comb begin
    aln_d         = '0;
    aln_d.sign    = cls_dat.sign;
    aln_d.nan     = cls_dat.nan;
    aln_d.inf     = cls_dat.inf;
    aln_d.flush   = cls_dat.flush;
    aln_d.pre_ovf = cls_dat.pre_ovf;
    rsh           = -cls_dat.shift;
    rwide         = '0;
    if (!cls_dat.shift[SW-1]) begin
      if (!cls_dat.pre_ovf)
        aln_d.mag = MagW'(cls_dat.sig) << cls_dat.shift;
    end else if (rsh >= SW'(MantissaWidth + 2)) begin
      aln_d.s = 1'b1;
    end else begin
      rwide     = {cls_dat.sig, {(MantissaWidth+2){1'b0}}} >> rsh;
      aln_d.mag = MagW'(rwide[RW-1:MantissaWidth+2]);
      aln_d.g   = rwide[MantissaWidth+1];
      aln_d.s   = |rwide[MantissaWidth:0];
    end
  end

  logic [MagW-1:0] mag_r;

  // Stage 3: round (or pass through) and range-check against the signed limits.
  always_comb begin
`ifdef FLOAT2FIX_ROUND_EN
    mag_r = aln_dat.mag + MagW'(aln_dat.g & (aln_dat.s | aln_dat.mag[0]));
`else
    mag_r = aln_dat.mag;
`endif
    rnd_d         = '0;
    rnd_d.sign    = aln_dat.sign;
    rnd_d.nan     = aln_dat.nan;
    rnd_d.inf     = aln_dat.inf;
    rnd_d.inexact = aln_dat.g | aln_dat.s | aln_dat.flush;
    rnd_d.ovf     = aln_dat.pre_ovf |
                    (aln_dat.sign ? (mag_r > NegMax) : (mag_r > PosMax));
    rnd_d.mag     = mag_r[IntWidth-1:0];
  end

  logic [IntWidth-1:0] res_d;
  logic                ovf_d, inx_d;

  // Stage 4: apply sign, then NaN/Inf/overflow override the value and flags.
  always_comb begin
    res_d = rnd_dat.sign ? -rnd_dat.mag : rnd_dat.mag;
    ovf_d = 1'b0;
    inx_d = rnd_dat.inexact;
    if (rnd_dat.nan) begin
      res_d = '0;
      ovf_d = 1'b1;
      inx_d = 1'b0;
    end else if (rnd_dat.inf | rnd_dat.ovf) begin
      res_d = rnd_dat.sign ? SatNeg : SatPos;
      ovf_d = 1'b1;
      inx_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      s4_vld  <= 1'b0;
      rdy     <= 1'b0;
      a_dat   <= '0;
      cls_dat <= '0;
      aln_dat <= '0;
      rnd_dat <= '0;
      Int_C   <= '0;
      ovf     <= 1'b0;
      inexact <= 1'b0;
    end else begin
      s1_vld <= en;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      s4_vld <= s3_vld;
      rdy    <= s4_vld;
      if (en)     a_dat   <= Float_A;
      if (s1_vld) cls_dat <= cls_d;
      if (s2_vld) aln_dat <= aln_d;
      if (s3_vld) rnd_dat <= rnd_d;
      // Result registers hold the last conversion between rdy pulses.
      if (s4_vld) begin
        Int_C   <= res_d;
        ovf     <= ovf_d;
        inexact <= inx_d;
      end
    end
  end

endmodule
